// File: rtl/avr_timer_pkg.sv
// avr_timer_pkg - shared definitions for the AVR-compatible timer/counter.
//   cs_e      : clock-select codes held in TCCR[2:0]
//   wgm_e     : waveform-generation codes held in TCCR[4:3]
//   OFF_*     : register offsets from the block base address
//   FLAG_*    : bit positions shared by TIFR (flags) and TIMSK (enables)
//   reg_addr  : base + offset folded to the 6-bit I/O address space
package avr_timer_pkg;

  typedef enum logic [2:0] {
    CS_STOP    = 3'd0,
    CS_CLK1    = 3'd1,
    CS_CLK8    = 3'd2,
    CS_CLK64   = 3'd3,
    CS_CLK256  = 3'd4,
    CS_CLK1024 = 3'd5,
    CS_T0_FALL = 3'd6,
    CS_T0_RISE = 3'd7
  } cs_e;

  // Code 3 is reserved and counts exactly like normal mode.
  typedef enum logic [1:0] {
    WGM_NORMAL   = 2'd0,
    WGM_CTC      = 2'd1,
    WGM_FAST_PWM = 2'd2,
    WGM_ALIAS    = 2'd3
  } wgm_e;

  localparam int OFF_TCNTL = 0;
  localparam int OFF_TCCR  = 1;
  localparam int OFF_OCRL  = 2;
  localparam int OFF_TIMSK = 3;
  localparam int OFF_TIFR  = 4;
  localparam int OFF_TCNTH = 5;
  localparam int OFF_OCRH  = 6;

  localparam int TCCR_COM_BIT = 5;

  localparam int FLAG_TOV = 0;
  localparam int FLAG_OCF = 1;

  function automatic logic [5:0] reg_addr(input int base, input int off);
    return 6'(base + off);
  endfunction

endpackage

// File: rtl/avr_timer_pwm_if.sv
// avr_timer_pwm_if - I/O-bus control signals shared by the core (master)
// and the timer peripheral (slave). The 8-bit bidirectional data bus stays
// a plain inout on the peripheral so that its tristate driver is explicit.
//   io_addr  : 6-bit register address
//   io_write : write strobe
//   io_read  : read strobe
//
// Handshake: io_write and io_read are single-cycle strobes qualified by
// io_addr. There is no back-pressure; a decoded write is accepted at the
// clock edge where the strobe is high, and read data is valid combinationally
// in the same cycle as io_read.
interface avr_timer_pwm_if;
  logic [5:0] io_addr;
  logic       io_write;
  logic       io_read;

  modport master (output io_addr, output io_write, output io_read);
  modport slave  (input  io_addr, input  io_write, input  io_read);
endinterface

// File: rtl/avr_timer_prescaler.sv
// avr_timer_prescaler - clock-select front end of the timer.
//   clk, rst : system clock, synchronous active-high reset
//   cs       : clock-select code
//   t0       : asynchronous external clock pin
//   tick     : one-cycle count enable for the counter
// The 10-bit prescaler free-runs and is cleared only by rst, so changing CS
// never restarts the division phase. T0 goes through two sync flops and an
// edge-detect flop, so a pin edge produces a counter step three edges later.
module avr_timer_prescaler
  import avr_timer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  cs_e  cs,
  input  logic t0,
  output logic tick
);

  logic [9:0] presc;
  logic       t0_s1;
  logic       t0_s2;
  logic       t0_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      t0_s1 <= 1'b0;
      t0_s2 <= 1'b0;
      t0_d  <= 1'b0;
    end else begin
      presc <= presc + 10'd1;
      t0_s1 <= t0;
      t0_s2 <= t0_s1;
      t0_d  <= t0_s2;
    end
  end

  // clk/N ticks in the single cycle where the low log2(N) bits are all ones.
  always_comb begin
    tick = 1'b0;
    case (cs)
      CS_STOP:    tick = 1'b0;
      CS_CLK1:    tick = 1'b1;
      CS_CLK8:    tick = &presc[2:0];
      CS_CLK64:   tick = &presc[5:0];
      CS_CLK256:  tick = &presc[7:0];
      CS_CLK1024: tick = &presc[9:0];
      CS_T0_FALL: tick = t0_d & ~t0_s2;
      CS_T0_RISE: tick = t0_s2 & ~t0_d;
      default:    tick = 1'b0;
    endcase
  end

endmodule

// File: rtl/avr_timer_pwm.sv
// avr_timer_pwm - AVR-compatible 8/16-bit timer/counter on the 6-bit I/O bus.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : io_addr / io_write / io_read (slave side)
//   io_data  : bidirectional data bus, driven only during a decoded read
//   T0       : asynchronous external clock pin
//   oc       : compare / PWM output pin
//   irq      : level interrupt request, |(TIFR & TIMSK)
// Registers at IO_ADDR+: 0 TCNTL, 1 TCCR, 2 OCRL, 3 TIMSK, 4 TIFR and, for
// WIDTH=16 only, 5 TCNTH, 6 OCRH. 16-bit accesses go through one shared TEMP
// byte so that multi-byte reads and writes are atomic with respect to counting.
module avr_timer_pwm
  import avr_timer_pkg::*;
#(
  parameter int IO_ADDR = 0,
  parameter int WIDTH   = 8
) (
  input  logic              clk,
  input  logic              rst,
  avr_timer_pwm_if.slave    bus,
  inout  wire  [7:0]        io_data,
  input  logic              T0,
  output logic              oc,
  output logic              irq
);

  localparam bit IS16 = (WIDTH == 16);

  localparam logic [5:0] A_TCNTL = reg_addr(IO_ADDR, OFF_TCNTL);
  localparam logic [5:0] A_TCCR  = reg_addr(IO_ADDR, OFF_TCCR);
  localparam logic [5:0] A_OCRL  = reg_addr(IO_ADDR, OFF_OCRL);
  localparam logic [5:0] A_TIMSK = reg_addr(IO_ADDR, OFF_TIMSK);
  localparam logic [5:0] A_TIFR  = reg_addr(IO_ADDR, OFF_TIFR);
  localparam logic [5:0] A_TCNTH = reg_addr(IO_ADDR, OFF_TCNTH);
  localparam logic [5:0] A_OCRH  = reg_addr(IO_ADDR, OFF_OCRH);

  logic [WIDTH-1:0] tcnt, tcnt_d;
  logic [WIDTH-1:0] ocr, ocr_d;
  logic [WIDTH-1:0] ocr_eff, ocr_eff_d;
  logic [WIDTH-1:0] ocr_cmp;
  logic [5:0]       tccr;
  logic [1:0]       timsk;
  logic [1:0]       tifr, tifr_d;
  logic [7:0]       temp, temp_d;
  logic             oc_q, oc_d;

  logic [15:0]      tcnt_ext, ocr_ext, wval16;
  logic             sel_tcntl, sel_tccr, sel_ocrl, sel_timsk, sel_tifr;
  logic             sel_tcnth, sel_ocrh;
  logic             wr_tcntl, wr_ocrl, wr_tcnth, wr_ocrh;
  logic             rd_tcntl, rd_ocrl;
  logic [7:0]       rdata;
  logic             rd_hit;

  logic             tick, step, at_max, match, com, is_ctc, is_pwm;
  wgm_e             wgm;

  // ---------------------------------------------------------------- decode
  assign sel_tcntl = (bus.io_addr == A_TCNTL);
  assign sel_tccr  = (bus.io_addr == A_TCCR);
  assign sel_ocrl  = (bus.io_addr == A_OCRL);
  assign sel_timsk = (bus.io_addr == A_TIMSK);
  assign sel_tifr  = (bus.io_addr == A_TIFR);
  assign sel_tcnth = IS16 && (bus.io_addr == A_TCNTH);
  assign sel_ocrh  = IS16 && (bus.io_addr == A_OCRH);

  assign wr_tcntl = bus.io_write & sel_tcntl;
  assign wr_ocrl  = bus.io_write & sel_ocrl;
  assign wr_tcnth = bus.io_write & sel_tcnth;
  assign wr_ocrh  = bus.io_write & sel_ocrh;
  assign rd_tcntl = bus.io_read & sel_tcntl;
  assign rd_ocrl  = bus.io_read & sel_ocrl;

  assign tcnt_ext = 16'(tcnt);
  assign ocr_ext  = 16'(ocr);
  // Low-byte writes commit {TEMP, data}; for WIDTH=8 the cast keeps only data.
  assign wval16   = {temp, io_data};

  // ------------------------------------------------------------ read mux
  always_comb begin
    rdata  = 8'h00;
    rd_hit = 1'b1;
    if (sel_tcntl)      rdata = tcnt_ext[7:0];
    else if (sel_tccr)  rdata = {2'b00, tccr};
    else if (sel_ocrl)  rdata = ocr_ext[7:0];
    else if (sel_timsk) rdata = {6'b0, timsk};
    else if (sel_tifr)  rdata = {6'b0, tifr};
    else if (sel_tcnth || sel_ocrh) rdata = temp;
    else rd_hit = 1'b0;
  end

  assign io_data = (bus.io_read && rd_hit) ? rdata : 8'hzz;

  // -------------------------------------------------------------- tick
  avr_timer_prescaler u_presc (
    .clk  (clk),
    .rst  (rst),
    .cs   (cs_e'(tccr[2:0])),
    .t0   (T0),
    .tick (tick)
  );

  assign wgm     = wgm_e'(tccr[4:3]);
  assign com     = tccr[TCCR_COM_BIT];
  assign is_ctc  = (wgm == WGM_CTC);
  assign is_pwm  = (wgm == WGM_FAST_PWM);
  assign ocr_cmp = is_pwm ? ocr_eff : ocr;
  assign at_max  = &tcnt;
  assign match   = (tcnt == ocr_cmp);
  // A TCNT write in the same cycle swallows the tick and its side effects.
  assign step    = tick & ~wr_tcntl;

  // ------------------------------------------------ counter next state
  always_comb begin
    tcnt_d = tcnt;
    if (wr_tcntl)
      tcnt_d = WIDTH'(wval16);
    else if (tick) begin
      if (is_ctc && match) tcnt_d = '0;
      else                 tcnt_d = tcnt + WIDTH'(1);
    end

    ocr_d = wr_ocrl ? WIDTH'(wval16) : ocr;

    // Fast PWM double-buffers OCR and swaps at the wrap; other modes follow
    // OCR directly so a later switch into PWM starts from the current value.
    if (is_pwm) ocr_eff_d = (step && at_max) ? ocr : ocr_eff;
    else        ocr_eff_d = ocr_d;

    temp_d = temp;
    if (IS16) begin
      if (rd_tcntl)     temp_d = tcnt_ext[15:8];
      else if (rd_ocrl) temp_d = ocr_ext[15:8];
      if (wr_tcnth || wr_ocrh) temp_d = io_data;
    end

    // Clear first so that a coincident set wins.
    tifr_d = tifr;
    if (bus.io_write && sel_tifr) tifr_d = tifr & ~io_data[1:0];
    if (step && at_max) tifr_d[FLAG_TOV] = 1'b1;
    if (step && match)  tifr_d[FLAG_OCF] = 1'b1;
  end

  // ------------------------------------------------------- output next
  always_comb begin
    oc_d = oc_q;
    if (!com)                oc_d = 1'b0;
    else if (is_pwm)         oc_d = (tcnt_d < ocr_eff_d);
    else if (step && match)  oc_d = ~oc_q;
  end

  // ----------------------------------------------------- state register
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt    <= '0;
      ocr     <= '0;
      ocr_eff <= '0;
      tccr    <= '0;
      timsk   <= '0;
      tifr    <= '0;
      temp    <= '0;
      oc_q    <= 1'b0;
    end else begin
      tcnt    <= tcnt_d;
      ocr     <= ocr_d;
      ocr_eff <= ocr_eff_d;
      tifr    <= tifr_d;
      temp    <= temp_d;
      oc_q    <= oc_d;
      if (bus.io_write && sel_tccr)  tccr  <= io_data[5:0];
      if (bus.io_write && sel_timsk) timsk <= io_data[1:0];
    end
  end

  assign oc  = oc_q & com;
  assign irq = |(tifr & timsk);

endmodule

// File: tb/tb_avr_timer_pwm.sv
// tb_avr_timer_pwm - directed bench for avr_timer_pwm. An 8-bit instance at
// I/O base 0 and a 16-bit instance at I/O base 16 share one bus.
module tb_avr_timer_pwm;

  logic       clk;
  logic       rst;
  logic       t0;
  logic       tb_drive;
  logic [7:0] tb_wdata;
  wire  [7:0] io_data;
  logic       oc8, irq8, oc16, irq16;

  int checks = 0;
  int errors = 0;

  avr_timer_pwm_if bus ();

  assign io_data = tb_drive ? tb_wdata : 8'hzz;

  avr_timer_pwm #(.IO_ADDR(0), .WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .bus(bus), .io_data(io_data),
    .T0(t0), .oc(oc8), .irq(irq8)
  );

  avr_timer_pwm #(.IO_ADDR(16), .WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .bus(bus), .io_data(io_data),
    .T0(t0), .oc(oc16), .irq(irq16)
  );

  // ------------------------------------------------ clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ------------------------------------------------ driver tasks
  task automatic bus_write(input logic [5:0] a, input logic [7:0] d);
    bus.io_addr = a; tb_wdata = d; tb_drive = 1'b1; bus.io_write = 1'b1;
    @(posedge clk); #1;
    bus.io_write = 1'b0; tb_drive = 1'b0;
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [7:0] d);
    bus.io_addr = a; bus.io_read = 1'b1;
    #1 d = io_data;
    @(posedge clk); #1;
    bus.io_read = 1'b0;
  endtask

  // ------------------------------------------------ tests
  task automatic test_reset();
    logic [7:0] v;
    bus_read(6'd0, v);  checks++; if (v !== 8'h00) begin errors++; $display("FAIL rst_tcnt8 got %h want 00", v); end
    bus_read(6'd1, v);  checks++; if (v !== 8'h00) begin errors++; $display("FAIL rst_tccr8 got %h want 00", v); end
    bus_read(6'd2, v);  checks++; if (v !== 8'h00) begin errors++; $display("FAIL rst_ocr8 got %h want 00", v); end
    bus_read(6'd3, v);  checks++; if (v !== 8'h00) begin errors++; $display("FAIL rst_timsk8 got %h want 00", v); end
    bus_read(6'd4, v);  checks++; if (v !== 8'h00) begin errors++; $display("FAIL rst_tifr8 got %h want 00", v); end
    bus_read(6'd21, v); checks++; if (v !== 8'h00) begin errors++; $display("FAIL rst_tcnth16 got %h want 00", v); end
    checks++; if ({oc8, irq8, oc16, irq16} !== 4'b0000) begin errors++; $display("FAIL rst_pins got %b want 0000", {oc8, irq8, oc16, irq16}); end
  endtask

  task automatic test_overflow();
    logic [7:0] v;
    bus_write(6'd3, 8'h01);          // TOIE
    bus_write(6'd1, 8'h01);          // normal, clk/1
    cyc(255);
    checks++; if (irq8 !== 1'b0) begin errors++; $display("FAIL ovf_irq_before got %b want 0", irq8); end
    bus_read(6'd0, v); checks++; if (v !== 8'hFF) begin errors++; $display("FAIL ovf_tcnt_max got %h want ff", v); end
    checks++; if (irq8 !== 1'b1) begin errors++; $display("FAIL ovf_irq got %b want 1", irq8); end
    // OCR=0 also matched on the 0-count ticks, so OCF is set as well.
    bus_read(6'd4, v); checks++; if (v !== 8'h03) begin errors++; $display("FAIL ovf_tifr got %h want 03", v); end
    bus_write(6'd4, 8'h01);          // clear TOV only
    checks++; if (irq8 !== 1'b0) begin errors++; $display("FAIL ovf_irq_clr got %b want 0", irq8); end
    bus_read(6'd4, v); checks++; if (v !== 8'h02) begin errors++; $display("FAIL ovf_tifr_clr got %h want 02", v); end
    bus_write(6'd4, 8'h02);
    bus_write(6'd1, 8'h00);
  endtask

  task automatic test_prescaler();
    logic [7:0] v;
    bit found;
    bus_write(6'd0, 8'h00);
    bus_write(6'd1, 8'h03);          // clk/64
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      bus_read(6'd0, v);
      if (v == 8'h01) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL presc_first_tick got none want tick within 80 cycles"); end
    cyc(62);
    bus_read(6'd0, v); checks++; if (v !== 8'h01) begin errors++; $display("FAIL presc_hold got %h want 01", v); end
    bus_read(6'd0, v); checks++; if (v !== 8'h02) begin errors++; $display("FAIL presc_step64 got %h want 02", v); end
    bus_write(6'd1, 8'h00);          // stop
    cyc(200);
    bus_read(6'd0, v); checks++; if (v !== 8'h02) begin errors++; $display("FAIL presc_frozen got %h want 02", v); end
  endtask

  task automatic test_ctc();
    logic [7:0] v;
    bus_write(6'd0, 8'h00);
    bus_write(6'd2, 8'h09);
    bus_write(6'd4, 8'h03);
    bus_write(6'd3, 8'h02);          // OCIE
    bus_write(6'd1, 8'h29);          // COM, CTC, clk/1
    cyc(9);
    bus_read(6'd0, v); checks++; if (v !== 8'h09) begin errors++; $display("FAIL ctc_top got %h want 09", v); end
    checks++; if (oc8 !== 1'b1) begin errors++; $display("FAIL ctc_oc_rise got %b want 1", oc8); end
    checks++; if (irq8 !== 1'b1) begin errors++; $display("FAIL ctc_irq got %b want 1", irq8); end
    bus_read(6'd4, v); checks++; if (v !== 8'h02) begin errors++; $display("FAIL ctc_tifr got %h want 02", v); end
    bus_write(6'd4, 8'h02);
    checks++; if (irq8 !== 1'b0) begin errors++; $display("FAIL ctc_irq_clr got %b want 0", irq8); end
    cyc(7);
    checks++; if (oc8 !== 1'b1) begin errors++; $display("FAIL ctc_oc_hold got %b want 1", oc8); end
    bus_read(6'd0, v); checks++; if (v !== 8'h09) begin errors++; $display("FAIL ctc_top2 got %h want 09", v); end
    checks++; if (oc8 !== 1'b0) begin errors++; $display("FAIL ctc_oc_fall got %b want 0", oc8); end
    bus_read(6'd4, v); checks++; if (v !== 8'h02) begin errors++; $display("FAIL ctc_no_tov got %h want 02", v); end
    bus_read(6'd0, v); checks++; if (v !== 8'h01) begin errors++; $display("FAIL ctc_wrap got %h want 01", v); end
    bus_write(6'd1, 8'h00);
    bus_write(6'd3, 8'h00);
  endtask

  task automatic test_pwm();
    logic [7:0] v;
    int cnt;
    bus_write(6'd0, 8'h00);
    bus_write(6'd2, 8'd64);
    bus_write(6'd4, 8'h03);
    bus_write(6'd1, 8'h31);          // COM, fast PWM, clk/1
    cyc(1);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin cnt += int'(oc8); cyc(1); end
    checks++; if (cnt !== 64) begin errors++; $display("FAIL pwm_duty64 got %0d want 64", cnt); end
    cyc(99);
    bus_write(6'd2, 8'd192);         // mid-period, TCNT becomes 101
    checks++; if (oc8 !== 1'b0) begin errors++; $display("FAIL pwm_no_early_update got %b want 0", oc8); end
    bus_read(6'd2, v); checks++; if (v !== 8'd192) begin errors++; $display("FAIL pwm_ocr_readback got %h want c0", v); end
    cnt = 0;
    for (int i = 0; i < 256; i++) begin cnt += int'(oc8); cyc(1); end
    checks++; if (cnt !== 102) begin errors++; $display("FAIL pwm_switch_at_wrap got %0d want 102", cnt); end
    cnt = 0;
    for (int i = 0; i < 256; i++) begin cnt += int'(oc8); cyc(1); end
    checks++; if (cnt !== 192) begin errors++; $display("FAIL pwm_duty192 got %0d want 192", cnt); end
    bus_write(6'd1, 8'h00);
  endtask

  task automatic test_16bit();
    logic [7:0] v;
    bus_write(6'd21, 8'h12);
    bus_write(6'd16, 8'h34);
    bus_read(6'd16, v); checks++; if (v !== 8'h34) begin errors++; $display("FAIL w16_lo got %h want 34", v); end
    bus_read(6'd21, v); checks++; if (v !== 8'h12) begin errors++; $display("FAIL w16_hi got %h want 12", v); end
    bus_write(6'd21, 8'h12);
    bus_write(6'd16, 8'hFF);
    bus_write(6'd17, 8'h01);         // count while reading
    bus_read(6'd16, v); checks++; if (v !== 8'hFF) begin errors++; $display("FAIL w16_atomic_lo got %h want ff", v); end
    bus_read(6'd21, v); checks++; if (v !== 8'h12) begin errors++; $display("FAIL w16_atomic_hi got %h want 12", v); end
    bus_read(6'd16, v); checks++; if (v !== 8'h01) begin errors++; $display("FAIL w16_lo2 got %h want 01", v); end
    bus_read(6'd21, v); checks++; if (v !== 8'h13) begin errors++; $display("FAIL w16_hi2 got %h want 13", v); end
    bus_write(6'd17, 8'h00);
    bus_write(6'd22, 8'hAB);
    bus_write(6'd18, 8'hCD);
    bus_read(6'd18, v); checks++; if (v !== 8'hCD) begin errors++; $display("FAIL w16_ocr_lo got %h want cd", v); end
    bus_read(6'd22, v); checks++; if (v !== 8'hAB) begin errors++; $display("FAIL w16_ocr_hi got %h want ab", v); end
  endtask

  task automatic test_t0();
    logic [7:0] v;
    bus_write(6'd21, 8'h00);
    bus_write(6'd16, 8'h00);
    bus_write(6'd17, 8'h07);         // T0 rising
    t0 = 1'b1;
    cyc(2);
    bus_read(6'd16, v); checks++; if (v !== 8'h00) begin errors++; $display("FAIL t0_latency got %h want 00", v); end
    bus_read(6'd16, v); checks++; if (v !== 8'h01) begin errors++; $display("FAIL t0_step got %h want 01", v); end
    cyc(5);
    bus_read(6'd16, v); checks++; if (v !== 8'h01) begin errors++; $display("FAIL t0_single got %h want 01", v); end
    t0 = 1'b0;
    cyc(5);
    bus_read(6'd16, v); checks++; if (v !== 8'h01) begin errors++; $display("FAIL t0_fall_ignored got %h want 01", v); end
    t0 = 1'b1;
    cyc(2);
    bus_read(6'd16, v); checks++; if (v !== 8'h01) begin errors++; $display("FAIL t0_latency2 got %h want 01", v); end
    bus_read(6'd16, v); checks++; if (v !== 8'h02) begin errors++; $display("FAIL t0_step2 got %h want 02", v); end
    t0 = 1'b0;
    cyc(5);
    bus_write(6'd21, 8'h00);
    t0 = 1'b1;
    cyc(2);
    bus_write(6'd16, 8'h50);         // lands on the tick edge
    bus_read(6'd16, v); checks++; if (v !== 8'h50) begin errors++; $display("FAIL t0_write_wins got %h want 50", v); end
    bus_read(6'd16, v); checks++; if (v !== 8'h50) begin errors++; $display("FAIL t0_write_wins2 got %h want 50", v); end
    bus_read(6'd20, v); checks++; if (v !== 8'h00) begin errors++; $display("FAIL t0_no_flags got %h want 00", v); end
    bus_write(6'd17, 8'h06);         // T0 falling
    t0 = 1'b0;
    cyc(2);
    bus_read(6'd16, v); checks++; if (v !== 8'h50) begin errors++; $display("FAIL t0f_latency got %h want 50", v); end
    bus_read(6'd16, v); checks++; if (v !== 8'h51) begin errors++; $display("FAIL t0f_step got %h want 51", v); end
    bus_write(6'd17, 8'h00);
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    bus_write(6'd21, 8'h77);         // TEMP pending
    bus_write(6'd17, 8'h01);
    cyc(3);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    checks++; if ({oc16, irq16} !== 2'b00) begin errors++; $display("FAIL rstm_pins got %b want 00", {oc16, irq16}); end
    bus_read(6'd17, v); checks++; if (v !== 8'h00) begin errors++; $display("FAIL rstm_tccr got %h want 00", v); end
    bus_write(6'd16, 8'h05);
    bus_read(6'd16, v); checks++; if (v !== 8'h05) begin errors++; $display("FAIL rstm_lo got %h want 05", v); end
    bus_read(6'd21, v); checks++; if (v !== 8'h00) begin errors++; $display("FAIL rstm_temp_discard got %h want 00", v); end
    bus_read(6'd0, v);  checks++; if (v !== 8'h00) begin errors++; $display("FAIL rstm_tcnt8 got %h want 00", v); end
  endtask

  // ------------------------------------------------ sequence + report
  initial begin
    rst = 1'b1; t0 = 1'b0; tb_drive = 1'b0; tb_wdata = 8'h00;
    bus.io_addr = 6'd0; bus.io_write = 1'b0; bus.io_read = 1'b0;
    cyc(3);
    rst = 1'b0;
    test_reset();
    test_overflow();
    test_prescaler();
    test_ctc();
    test_pwm();
    test_16bit();
    test_t0();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
